// File: rtl/gmii_tx_pkg.sv
// rtl/gmii_tx_pkg.sv - shared constants, CRC32 parameters and state type for the GMII transmit framer
package gmii_tx_pkg;

  localparam logic [7:0]  ETH_PRE    = 8'h55;
  localparam logic [7:0]  ETH_SFD    = 8'hD5;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Ethernet shifts bytes LSB first, so the CRC runs on the bit-reversed polynomial.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC32_POLY_REFL = bit_reverse32(CRC32_POLY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DRAIN
  } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational reflected CRC32 update over one byte
module crc32_d8
  import gmii_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Fold the byte in, then shift out eight bits LSB first.
  always_comb begin
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - AXI-stream to GMII transmit framer; define GMII_TX_PAD_EN to pad short frames
module gmii_tx_framer
  import gmii_tx_pkg::*;
#(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG              = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       start_packet,
  output logic       error_underflow
);

  localparam logic [15:0] IFG_LAST = 16'(IFG - 1);
`ifdef GMII_TX_PAD_EN
  localparam logic [15:0] MIN_DATA = 16'(MIN_FRAME_LENGTH - 4);
`endif

  tx_state_t   state, state_next;
  logic [15:0] byte_cnt, byte_cnt_next, byte_inc;
  logic [15:0] phase_cnt, phase_next;
  logic [31:0] crc, crc_next, crc_upd;
  logic [7:0]  crc_data, fcs_byte;
  logic        tuser_q, tuser_next;
  logic [7:0]  txd_next;
  logic        tx_en_next, tx_er_next, tready_next, start_next, underflow_next;

  // Pad bytes are zeros but still go through the CRC.
  assign crc_data = (state == ST_PAD) ? 8'h00 : s_axis_tdata;
  // The length counter only steers padding, so saturating is harmless for jumbo frames.
  assign byte_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_data),
    .crc_out (crc_upd)
  );

  // FCS is the inverted CRC sent least-significant byte first.
  always_comb begin
    fcs_byte = 8'h00;
    case (phase_cnt[1:0])
      2'd0:    fcs_byte = ~crc[7:0];
      2'd1:    fcs_byte = ~crc[15:8];
      2'd2:    fcs_byte = ~crc[23:16];
      default: fcs_byte = ~crc[31:24];
    endcase
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_next     = state;
    byte_cnt_next  = byte_cnt;
    phase_next     = phase_cnt;
    crc_next       = crc;
    tuser_next     = tuser_q;
    txd_next       = 8'h00;
    tx_en_next     = 1'b0;
    tx_er_next     = 1'b0;
    tready_next    = 1'b0;
    start_next     = 1'b0;
    underflow_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          state_next = ST_PREAMBLE;
          phase_next = 16'd0;
        end
      end
      ST_PREAMBLE: begin
        tx_en_next = 1'b1;
        start_next = (phase_cnt == 16'd0);
        txd_next   = (phase_cnt == 16'd7) ? ETH_SFD : ETH_PRE;
        phase_next = phase_cnt + 16'd1;
        if (phase_cnt == 16'd7) begin
          // tready rises together with the SFD so the first byte lands right behind it.
          state_next    = ST_PAYLOAD;
          tready_next   = 1'b1;
          byte_cnt_next = 16'd0;
          crc_next      = CRC32_INIT;
        end
      end
      ST_PAYLOAD: begin
        // tready is always high here, so tvalid alone decides accept versus underflow.
        tx_en_next = 1'b1;
        if (s_axis_tvalid) begin
          txd_next      = s_axis_tdata;
          crc_next      = crc_upd;
          byte_cnt_next = byte_inc;
          if (s_axis_tlast) begin
            tuser_next = s_axis_tuser;
            phase_next = 16'd0;
`ifdef GMII_TX_PAD_EN
            state_next = (byte_inc < MIN_DATA) ? ST_PAD : ST_FCS;
`else
            state_next = ST_FCS;
`endif
          end else begin
            tready_next = 1'b1;
          end
        end else begin
          tx_er_next     = 1'b1;
          underflow_next = 1'b1;
          tready_next    = 1'b1;
          state_next     = ST_DRAIN;
        end
      end
`ifdef GMII_TX_PAD_EN
      ST_PAD: begin
        tx_en_next    = 1'b1;
        crc_next      = crc_upd;
        byte_cnt_next = byte_inc;
        if (byte_inc >= MIN_DATA) begin
          state_next = ST_FCS;
          phase_next = 16'd0;
        end
      end
`endif
      ST_FCS: begin
        tx_en_next = 1'b1;
        txd_next   = fcs_byte;
        tx_er_next = (phase_cnt == 16'd3) && tuser_q;
        phase_next = phase_cnt + 16'd1;
        if (phase_cnt == 16'd3) begin
          state_next = ST_IFG;
          phase_next = 16'd0;
        end
      end
      ST_IFG: begin
        phase_next = phase_cnt + 16'd1;
        if (phase_cnt >= IFG_LAST) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        tready_next = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          tready_next = 1'b0;
          state_next  = ST_IFG;
          phase_next  = 16'd0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset silences the PHY pins immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      byte_cnt        <= 16'd0;
      phase_cnt       <= 16'd0;
      crc             <= CRC32_INIT;
      tuser_q         <= 1'b0;
      gmii_txd        <= 8'h00;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      s_axis_tready   <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      state           <= state_next;
      byte_cnt        <= byte_cnt_next;
      phase_cnt       <= phase_next;
      crc             <= crc_next;
      tuser_q         <= tuser_next;
      gmii_txd        <= txd_next;
      gmii_tx_en      <= tx_en_next;
      gmii_tx_er      <= tx_er_next;
      s_axis_tready   <= tready_next;
      start_packet    <= start_next;
      error_underflow <= underflow_next;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - randomized self-checking bench for gmii_tx_framer against a frame-level model
module tb_gmii_tx_framer;

  localparam int MIN_FRAME_LENGTH = 64;
  localparam int IFG              = 12;
`ifdef GMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, start_packet, error_underflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pl[$], pl1[$], pl2[$];
  logic [7:0] exp_b[$], got_b[$];
  logic       exp_e[$], got_e[$];
  int         got_gap;

  logic [7:0] cur_b[$], mon_b[$];
  logic       cur_e[$], mon_e[$];
  int         mon_len[$], mon_gap[$];
  int         gap = 1000;
  int         sp_cnt = 0, uf_cnt = 0;

  always #4 clk = ~clk;

  gmii_tx_framer #(.MIN_FRAME_LENGTH(MIN_FRAME_LENGTH), .IFG(IFG)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .start_packet(start_packet), .error_underflow(error_underflow)
  );

  // Collect each tx_en burst as one frame, with the idle gap that preceded it.
  always @(negedge clk) begin
    if (gmii_tx_en) begin
      if (cur_b.size() == 0) mon_gap.push_back(gap);
      cur_b.push_back(gmii_txd);
      cur_e.push_back(gmii_tx_er);
      gap <= 0;
    end else begin
      if (cur_b.size() != 0) begin
        mon_len.push_back(cur_b.size());
        for (int i = 0; i < cur_b.size(); i++) begin
          mon_b.push_back(cur_b[i]);
          mon_e.push_back(cur_e[i]);
        end
        cur_b.delete();
        cur_e.delete();
      end
      gap <= gap + 1;
    end
    if (start_packet) sp_cnt <= sp_cnt + 1;
    if (error_underflow) uf_cnt <= uf_cnt + 1;
  end

  // Reference: what the wire must carry for payload pl.
  task automatic build_exp(input logic user);
    logic [7:0]  body[$];
    logic [31:0] c;
    exp_b.delete();
    exp_e.delete();
    body = pl;
    if (PAD_EN) while (body.size() < MIN_FRAME_LENGTH - 4) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      c ^= {24'h0, body[i]};
      for (int k = 0; k < 8; k++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    c = ~c;
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    foreach (body[i]) exp_b.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_b.push_back(8'(c >> (8 * i)));
    foreach (exp_b[i]) exp_e.push_back(1'b0);
    exp_e[exp_e.size()-1] = user;
  endtask

  function automatic int diff_bytes();
    int n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) if (got_b[i] !== exp_b[i]) return i;
    return (got_b.size() == exp_b.size()) ? -1 : n;
  endfunction

  function automatic int diff_er();
    int n = (got_e.size() < exp_e.size()) ? got_e.size() : exp_e.size();
    for (int i = 0; i < n; i++) if (got_e[i] !== exp_e[i]) return i;
    return (got_e.size() == exp_e.size()) ? -1 : n;
  endfunction

  task automatic fill_random(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic clear_mon();
    @(posedge clk);
    mon_b.delete(); mon_e.delete(); mon_len.delete(); mon_gap.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int n = 0;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last; s_axis_tuser = user;
    while (s_axis_tready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL handshake_timeout tready=%b required=1", s_axis_tready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic user, input bit hold, input bit noise);
    for (int i = 0; i < pl.size(); i++) begin
      if (i == pl.size() - 1) send_byte(pl[i], 1'b1, user);
      else send_byte(pl[i], 1'b0, noise ? 1'($urandom) : 1'b0);
    end
    if (!hold) begin s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; end
  endtask

  task automatic wait_frames(input int k);
    int n = 0;
    while (mon_len.size() < k && n < 2000) begin @(posedge clk); n++; end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL frame_timeout frames=%0d required=%0d", mon_len.size(), k);
    end
  endtask

  task automatic pop_frame();
    int len;
    got_b.delete(); got_e.delete(); got_gap = -1;
    if (mon_len.size() == 0) return;
    len = mon_len.pop_front();
    got_gap = mon_gap.pop_front();
    for (int i = 0; i < len; i++) begin
      got_b.push_back(mon_b.pop_front());
      got_e.push_back(mon_e.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bit bad = 0;
    rst = 1'b1; s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    idle(3);
    checks++;
    if ({gmii_txd, gmii_tx_en, gmii_tx_er, s_axis_tready, start_packet, error_underflow} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0",
               {gmii_txd, gmii_tx_en, gmii_tx_er, s_axis_tready, start_packet, error_underflow});
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gmii_tx_en !== 1'b0 || s_axis_tready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL idle_quiet got=1 required=0"); end
  endtask

  task automatic test_single_byte();
    int sp0;
    clear_mon();
    sp0 = sp_cnt;
    pl.delete(); pl.push_back(8'h01);
    @(negedge clk);
    s_axis_tdata = 8'h01; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tuser = 1'b0;
    @(negedge clk);
    checks++;
    if (gmii_tx_en !== 1'b0) begin failures++; $display("FAIL latency_en_early got=%b required=0", gmii_tx_en); end
    @(negedge clk);
    checks++;
    if ({gmii_tx_en, gmii_txd, start_packet} !== {1'b1, 8'h55, 1'b1}) begin
      failures++; $display("FAIL first_preamble got=%h required=%h", {gmii_tx_en, gmii_txd, start_packet}, {1'b1, 8'h55, 1'b1});
    end
    idle(7);
    checks++;
    if ({gmii_txd, s_axis_tready} !== {8'hD5, 1'b1}) begin
      failures++; $display("FAIL sfd_ready got=%h required=%h", {gmii_txd, s_axis_tready}, {8'hD5, 1'b1});
    end
    @(negedge clk);
    checks++;
    if (gmii_txd !== 8'h01) begin failures++; $display("FAIL first_payload got=%h required=01", gmii_txd); end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    wait_frames(1);
    pop_frame();
    build_exp(1'b0);
    checks++;
    if (got_b.size() !== (PAD_EN ? 72 : 13)) begin
      failures++; $display("FAIL single_len got=%0d required=%0d", got_b.size(), PAD_EN ? 72 : 13);
    end
    checks++;
    if (diff_bytes() != -1) begin
      failures++; $display("FAIL single_data idx=%0d got=%h required=%h", diff_bytes(), got_b[diff_bytes()], exp_b[diff_bytes()]);
    end
    checks++;
    if (sp_cnt - sp0 !== 1) begin failures++; $display("FAIL start_pulses got=%0d required=1", sp_cnt - sp0); end
    idle(IFG + 4);
  endtask

  task automatic test_lengths();
    int lens[6];
    int exp_len;
    lens = '{59, 60, 61, 64, 2 + $urandom_range(0, 56), 61 + $urandom_range(0, 60)};
    foreach (lens[j]) begin
      clear_mon();
      fill_random(lens[j]);
      @(negedge clk);
      send_frame(1'b0, 1'b0, 1'b0);
      wait_frames(1);
      pop_frame();
      build_exp(1'b0);
      exp_len = 12 + ((PAD_EN && lens[j] < 60) ? 60 : lens[j]);
      checks++;
      if (got_b.size() !== exp_len) begin
        failures++; $display("FAIL len_p%0d got=%0d required=%0d", lens[j], got_b.size(), exp_len);
      end
      checks++;
      if (diff_bytes() != -1) begin
        failures++; $display("FAIL data_p%0d idx=%0d got=%h required=%h", lens[j], diff_bytes(), got_b[diff_bytes()], exp_b[diff_bytes()]);
      end
      checks++;
      if (diff_er() != -1) begin failures++; $display("FAIL er_p%0d idx=%0d got=1 required=0", lens[j], diff_er()); end
      idle(IFG + 4);
    end
  endtask

  task automatic test_long_frame();
    clear_mon();
    pl.delete();
    for (int i = 0; i < 100; i++) pl.push_back(8'(i));
    @(negedge clk);
    send_frame(1'b0, 1'b0, 1'b0);
    wait_frames(1);
    pop_frame();
    build_exp(1'b0);
    checks++;
    if (got_b.size() !== 112) begin failures++; $display("FAIL long_len got=%0d required=112", got_b.size()); end
    checks++;
    if (diff_bytes() != -1) begin
      failures++; $display("FAIL long_data idx=%0d got=%h required=%h", diff_bytes(), got_b[diff_bytes()], exp_b[diff_bytes()]);
    end
    checks++;
    if (diff_er() != -1) begin failures++; $display("FAIL long_er idx=%0d got=1 required=0", diff_er()); end
    idle(IFG + 4);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    fill_random(64); pl1 = pl;
    fill_random(64); pl2 = pl;
    @(negedge clk);
    pl = pl1; send_frame(1'b0, 1'b1, 1'b0);
    pl = pl2; send_frame(1'b0, 1'b0, 1'b0);
    wait_frames(2);
    pl = pl1; build_exp(1'b0); pop_frame();
    checks++;
    if (diff_bytes() != -1) begin failures++; $display("FAIL b2b_first idx=%0d got=%0d required=%0d", diff_bytes(), got_b.size(), exp_b.size()); end
    pl = pl2; build_exp(1'b0); pop_frame();
    checks++;
    if (diff_bytes() != -1) begin failures++; $display("FAIL b2b_second idx=%0d got=%0d required=%0d", diff_bytes(), got_b.size(), exp_b.size()); end
    checks++;
    if (got_gap !== IFG + 1) begin failures++; $display("FAIL b2b_gap got=%0d required=%0d", got_gap, IFG + 1); end
    idle(IFG + 4);
  endtask

  task automatic test_underflow();
    int uf0;
    clear_mon();
    uf0 = uf_cnt;
    fill_random(30);
    @(negedge clk);
    for (int i = 0; i < 20; i++) send_byte(pl[i], 1'b0, 1'b0);
    s_axis_tvalid = 1'b0;
    idle(3);
    for (int i = 20; i < 30; i++) send_byte(pl[i], i == 29, 1'b0);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    wait_frames(1);
    pop_frame();
    exp_b.delete(); exp_e.delete();
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    for (int i = 0; i < 20; i++) exp_b.push_back(pl[i]);
    exp_b.push_back(8'h00);
    foreach (exp_b[i]) exp_e.push_back(i == exp_b.size() - 1);
    checks++;
    if (diff_bytes() != -1) begin failures++; $display("FAIL uf_data idx=%0d got=%0d required=%0d", diff_bytes(), got_b.size(), exp_b.size()); end
    checks++;
    if (diff_er() != -1) begin failures++; $display("FAIL uf_er idx=%0d got=%b required=%b", diff_er(), got_e[diff_er()], exp_e[diff_er()]); end
    checks++;
    if (uf_cnt - uf0 !== 1) begin failures++; $display("FAIL uf_pulse got=%0d required=1", uf_cnt - uf0); end
    idle(40);
    checks++;
    if (mon_len.size() !== 0 || gmii_tx_en !== 1'b0) begin
      failures++; $display("FAIL uf_drained_silent got=%0d required=0", mon_len.size());
    end
  endtask

  task automatic test_tuser();
    logic users[2];
    users = '{1'b1, 1'b0};
    foreach (users[j]) begin
      clear_mon();
      fill_random(60);
      @(negedge clk);
      send_frame(users[j], 1'b0, 1'b1);
      wait_frames(1);
      pop_frame();
      build_exp(users[j]);
      checks++;
      if (diff_bytes() != -1) begin failures++; $display("FAIL tuser%0d_data idx=%0d got=%0d required=%0d", users[j], diff_bytes(), got_b.size(), exp_b.size()); end
      checks++;
      if (diff_er() != -1) begin
        failures++; $display("FAIL tuser%0d_er idx=%0d got=%b required=%b", users[j], diff_er(), got_e[diff_er()], exp_e[diff_er()]);
      end
      idle(IFG + 4);
    end
  endtask

  task automatic test_reset_midframe();
    fill_random(40);
    @(negedge clk);
    for (int i = 0; i < 30; i++) send_byte(pl[i], 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gmii_tx_en, gmii_tx_er, gmii_txd, s_axis_tready} !== 11'h0) begin
      failures++; $display("FAIL async_reset got=%h required=0", {gmii_tx_en, gmii_tx_er, gmii_txd, s_axis_tready});
    end
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    clear_mon();
    fill_random(10 + $urandom_range(0, 70));
    @(negedge clk);
    send_frame(1'b0, 1'b0, 1'b0);
    wait_frames(1);
    pop_frame();
    build_exp(1'b0);
    checks++;
    if (diff_bytes() != -1) begin failures++; $display("FAIL post_reset_data idx=%0d got=%0d required=%0d", diff_bytes(), got_b.size(), exp_b.size()); end
    checks++;
    if (diff_er() != -1) begin failures++; $display("FAIL post_reset_er idx=%0d got=1 required=0", diff_er()); end
    idle(IFG + 4);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_lengths();
    test_long_frame();
    test_back_to_back();
    test_underflow();
    test_tuser();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
